// File: rtl/intr_seq_ctrl_pkg.sv
// Shared types and constants for the interrupt / return-from-interrupt sequencer.
package intr_seq_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DRAIN    = 4'd1,
        ST_PUSH_HI  = 4'd2,
        ST_PUSH_LO  = 4'd3,
        ST_PUSH_CCR = 4'd4,
        ST_VECTOR   = 4'd5,
        ST_RDRAIN   = 4'd6,
        ST_POP_CCR  = 4'd7,
        ST_POP_LO   = 4'd8,
        ST_POP_HI   = 4'd9,
        ST_RESTORE  = 4'd10
    } state_t;

    // Stack frame word selectors; pops walk them in reverse.
    localparam logic [1:0] WORD_PC_HI = 2'd0;
    localparam logic [1:0] WORD_PC_LO = 2'd1;
    localparam logic [1:0] WORD_CCR   = 2'd2;

    localparam logic [31:0] DEF_INT_VECTOR = 32'h0000_0020;

    function automatic logic [15:0] stack_word(input logic [1:0] sel,
                                               input logic [31:0] pc,
                                               input logic [2:0] ccr);
        case (sel)
            WORD_PC_HI: return pc[31:16];
            WORD_PC_LO: return pc[15:0];
            default:    return {13'b0, ccr};
        endcase
    endfunction

endpackage

// File: rtl/intr_seq_ctrl_if.sv
// Data-memory stack port shared with the MEM stage through a req/gnt handshake.
interface intr_seq_ctrl_if;
    logic        stk_req;
    logic        stk_we;
    logic [15:0] stk_wdata;
    logic        stk_gnt;
    logic [15:0] stk_rdata;
    logic        stk_rvalid;

    modport master (output stk_req, stk_we, stk_wdata,
                    input  stk_gnt, stk_rdata, stk_rvalid);
    modport slave  (input  stk_req, stk_we, stk_wdata,
                    output stk_gnt, stk_rdata, stk_rvalid);
endinterface

// File: rtl/intr_seq_ctrl_sync_edge.sv
// 2-FF synchroniser for the external interrupt, rising-edge detect and one-deep pending flag.
module intr_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    input  logic clr,
    output logic pending
);
    logic sync1, sync2, sync_d;
    logic rise;

    assign rise = sync2 & ~sync_d;

    // A new edge wins over a same-cycle clear so it is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync_d  <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync1  <= async_in;
            sync2  <= sync1;
            sync_d <= sync2;
            if (rise)
                pending <= 1'b1;
            else if (clr)
                pending <= 1'b0;
        end
    end
endmodule

// File: rtl/intr_seq_ctrl.sv
// Interrupt entry / RTI sequencer: drains the pipe, pushes or pops PC+CCR, redirects fetch.
//   state    | meaning
//   IDLE     | waiting for pending interrupt or RTI
//   DRAIN    | fetch stalled, in-flight instructions retiring (entry)
//   PUSH_*   | writing ret_pc hi, ret_pc lo, CCR to stack
//   VECTOR   | redirect PC to the interrupt vector
//   RDRAIN   | fetch stalled, pipe draining (RTI)
//   POP_*    | reading CCR, pc lo, pc hi back from stack
//   RESTORE  | load restored PC and CCR
module intr_seq_ctrl
    import intr_seq_ctrl_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter logic [PC_W-1:0] INT_VECTOR   = DEF_INT_VECTOR,
    parameter int              DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 intr,
    input  logic                 rti_dec,
    input  logic                 pipe_busy,
    input  logic [PC_W-1:0]      pc_cur,
    input  logic [2:0]           ccr_cur,
    intr_seq_ctrl_if.master      stk,
    output logic                 fetch_stall,
    output logic                 flush_ifid,
    output logic                 pc_load,
    output logic [PC_W-1:0]      pc_load_val,
    output logic                 ccr_load,
    output logic [2:0]           ccr_load_val,
    output logic                 intr_ack,
    output logic                 seq_busy
);
    localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [PC_W-1:0] ret_pc, ret_pc_nxt;
    logic [2:0]      sav_ccr, sav_ccr_nxt;
    logic [2:0]      ccr_val, ccr_val_nxt;
    logic            gnt_seen, gnt_seen_nxt;
    logic            pending;
    logic [1:0]      push_sel;

    intr_sync_edge u_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .async_in (intr),
        .clr      (intr_ack),
        .pending  (pending)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ret_pc   <= '0;
            sav_ccr  <= '0;
            ccr_val  <= '0;
            gnt_seen <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ret_pc   <= ret_pc_nxt;
            sav_ccr  <= sav_ccr_nxt;
            ccr_val  <= ccr_val_nxt;
            gnt_seen <= gnt_seen_nxt;
        end
    end

    assign fetch_stall  = (state != ST_IDLE);
    assign seq_busy     = (state != ST_IDLE);
    assign ccr_load_val = ccr_val;
    assign push_sel     = (state == ST_PUSH_HI) ? WORD_PC_HI :
                          (state == ST_PUSH_LO) ? WORD_PC_LO : WORD_CCR;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        ret_pc_nxt    = ret_pc;
        sav_ccr_nxt   = sav_ccr;
        ccr_val_nxt   = ccr_val;
        gnt_seen_nxt  = gnt_seen;
        stk.stk_req   = 1'b0;
        stk.stk_we    = 1'b0;
        stk.stk_wdata = '0;
        flush_ifid    = 1'b0;
        pc_load       = 1'b0;
        pc_load_val   = '0;
        ccr_load      = 1'b0;
        intr_ack      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (pending && !pipe_busy) begin
                    intr_ack    = 1'b1;
                    flush_ifid  = 1'b1;
                    ret_pc_nxt  = pc_cur;
                    sav_ccr_nxt = ccr_cur;
                    cnt_nxt     = CNT_INIT;
                    state_nxt   = ST_DRAIN;
                end else if (rti_dec) begin
                    flush_ifid = 1'b1;
                    cnt_nxt    = CNT_INIT;
                    state_nxt  = ST_RDRAIN;
                end
            end
            ST_DRAIN, ST_RDRAIN: begin
                if (cnt == 4'd0)
                    state_nxt = (state == ST_DRAIN) ? ST_PUSH_HI : ST_POP_CCR;
                else
                    cnt_nxt = cnt - 4'd1;
            end
            ST_PUSH_HI, ST_PUSH_LO, ST_PUSH_CCR: begin
                stk.stk_req   = 1'b1;
                stk.stk_we    = 1'b1;
                stk.stk_wdata = stack_word(push_sel, 32'(ret_pc), sav_ccr);
                if (stk.stk_gnt)
                    state_nxt = (state == ST_PUSH_HI) ? ST_PUSH_LO :
                                (state == ST_PUSH_LO) ? ST_PUSH_CCR : ST_VECTOR;
            end
            ST_VECTOR: begin
                pc_load     = 1'b1;
                pc_load_val = INT_VECTOR;
                state_nxt   = ST_IDLE;
            end
            // Request until granted, then wait for the read data one cycle later.
            ST_POP_CCR, ST_POP_LO, ST_POP_HI: begin
                stk.stk_req = !gnt_seen;
                if (!gnt_seen && stk.stk_gnt)
                    gnt_seen_nxt = 1'b1;
                if (gnt_seen && stk.stk_rvalid) begin
                    gnt_seen_nxt = 1'b0;
                    case (state)
                        ST_POP_CCR: begin
                            ccr_val_nxt = stk.stk_rdata[2:0];
                            state_nxt   = ST_POP_LO;
                        end
                        ST_POP_LO: begin
                            ret_pc_nxt[15:0] = stk.stk_rdata;
                            state_nxt        = ST_POP_HI;
                        end
                        default: begin
                            ret_pc_nxt[31:16] = stk.stk_rdata;
                            state_nxt         = ST_RESTORE;
                        end
                    endcase
                end
            end
            ST_RESTORE: begin
                pc_load     = 1'b1;
                pc_load_val = ret_pc;
                ccr_load    = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: doc/intr_seq_ctrl.md
Name: intr_seq_ctrl

Overview:
- Interrupt and return-from-interrupt sequencer for the 5-stage pipeline.
- On an external interrupt it stalls fetch, drains in-flight instructions, pushes the return PC (two 16-bit words) and CCR to the data-memory stack, then redirects fetch to the interrupt vector.
- On RTI it pops CCR and PC in reverse order and restores them.
- Shares the data-memory port with the MEM stage through a req/gnt handshake.

Parameters:
- INT_VECTOR, 32'h0000_0020, PC loaded on interrupt entry.
- DRAIN_CYCLES, 3, cycles to wait after stalling fetch so ID/EX/MEM retire (1..15).
- PC_W, 32, program counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- intr  in  1  external interrupt, asynchronous, rising-edge significant
- rti_dec  in  1  RTI decoded in ID this cycle
- pipe_busy  in  1  multi-cycle instruction in flight (LDM 2nd word, CALL/RET); blocks entry
- pc_cur  in  32  address of next unexecuted instruction (return address)
- ccr_cur  in  3  current CCR
- stk_req  out  1  stack access request
- stk_we  out  1  1 = push (write), 0 = pop (read); valid with stk_req
- stk_wdata  out  16  push data
- stk_gnt  in  1  memory port granted this cycle
- stk_rdata  in  16  pop data
- stk_rvalid  in  1  stk_rdata valid (cycle after read grant)
- fetch_stall  out  1  hold PC and IF/ID
- flush_ifid  out  1  one-cycle pulse, bubble IF/ID
- pc_load  out  1  one-cycle pulse, PC <= pc_load_val
- pc_load_val  out  32  redirect target
- ccr_load  out  1  one-cycle pulse, CCR <= ccr_load_val
- ccr_load_val  out  3  restored CCR
- intr_ack  out  1  one-cycle pulse on entry to DRAIN
- seq_busy  out  1  FSM not IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, sync flops 0, pending 0, counter 0. Reset mid-sequence aborts immediately; no partial push is retried.
- Input capture:
  - intr passes through a 2-FF synchroniser; a rising edge of the synchronised signal sets `pending`.
  - `pending` clears on the intr_ack cycle.
  - An edge during any non-IDLE state stays pending (one deep); further edges merge.
- FSM:
  - IDLE:
    - If pending and !pipe_busy, go to DRAIN: intr_ack=1, flush_ifid=1, latch ret_pc<=pc_cur and sav_ccr<=ccr_cur, cnt<=DRAIN_CYCLES-1.
    - Else if rti_dec, go to RDRAIN: flush_ifid=1, cnt<=DRAIN_CYCLES-1.
    - If pending and rti_dec arrive together, the interrupt wins. The RTI's PC is saved, so the RTI re-executes after the handler.
  - DRAIN / RDRAIN: fetch_stall=1; decrement cnt; at cnt==0 go to PUSH_HI / POP_CCR.
  - PUSH_HI, PUSH_LO, PUSH_CCR:
    - Assert stk_req=1, stk_we=1 with stk_wdata = ret_pc[31:16], ret_pc[15:0], {13'b0,sav_ccr} respectively.
    - Hold request and data stable until stk_gnt, then advance. PUSH_CCR goes to VECTOR.
  - VECTOR: pc_load=1, pc_load_val=INT_VECTOR; go to IDLE.
  - POP_CCR, POP_LO, POP_HI:
    - Assert stk_req=1, stk_we=0 until stk_gnt; drop stk_req after grant.
    - Capture stk_rdata on stk_rvalid: POP_CCR captures [2:0] into ccr_load_val, POP_LO captures ret_pc[15:0], POP_HI captures ret_pc[31:16]; then advance.
    - POP_HI goes to RESTORE.
  - RESTORE: pc_load=1, pc_load_val=ret_pc, ccr_load=1; go to IDLE. If pending, the next IDLE cycle may immediately start a new entry (tail-chain).
- fetch_stall=1 in every state except IDLE.
- seq_busy = (state != IDLE).
- Latency, zero wait states, DRAIN_CYCLES=3:
  - Interrupt entry: intr edge to intr_ack is 3 cycles. intr_ack to pc_load is 3 drain + 3 push + 1 = 7 cycles.
  - RTI: 3 drain + 3×2 pop + 1 restore.
- rti_dec is ignored while not IDLE.

Decomposition:
- Shared package holds:
  - state encoding localparams (4-bit: IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_CCR, VECTOR, RDRAIN, POP_CCR, POP_LO, POP_HI, RESTORE);
  - the push/pop word order constants;
  - the default INT_VECTOR.
- One sub-module: intr_sync_edge (2-FF synchroniser, rising-edge detector and pending flag, with clear input).

Test Plan:
- Interrupt entry: pulse intr, pc_cur=32'h0001_2345, ccr_cur=3'b101, stk_gnt tied 1 -> intr_ack 3 cycles later. Pushes are 16'h0001, 16'h2345, 16'h0005 on consecutive cycles, then pc_load=1 with pc_load_val=32'h20. fetch_stall is high throughout.
- RTI: rti_dec=1 in IDLE; stk_rdata returns 5, 16'h2345, 16'h0001 -> RESTORE pulses pc_load with 32'h0001_2345 and ccr_load with 3'b101 in the same cycle.
- Grant wait: stk_gnt held 0 for 4 cycles in PUSH_LO -> stk_req, stk_we and stk_wdata=16'h2345 stay stable; FSM advances only on the grant cycle.
- Blocking and priority:
  - intr pending while pipe_busy=1 for 5 cycles -> no intr_ack until pipe_busy falls.
  - intr and rti_dec in the same cycle -> interrupt sequence taken, RTI's PC pushed.
- Tail-chain: second intr edge during PUSH_HI -> after VECTOR, a new intr_ack is issued immediately from IDLE; only one extra entry even with 3 edges.
- Reset mid-sequence: assert rst=0 during POP_LO -> all outputs 0 asynchronously; after release the FSM is IDLE and no pc_load occurs.
